// File: rtl/modmul_scheduler.sv
// -----------------------------------------------------------------------------
// modmul_scheduler
//
// Front end for a shared, fixed-latency modular-multiply datapath. Two
// requesters take turns (round-robin) issuing operand pairs, at most one per
// cycle. Each issue carries a tag down a LAT+1 deep shift register, so the
// datapath result comes back to the requester that issued it, in issue order.
// A new modulus set is accepted only after every operation already in flight
// has returned. This keeps dp_q/dp_mu/dp_k stable under every op.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   cfg_valid/cfg_ready     modulus-set load handshake
//   cfg_q, cfg_mu, cfg_k    modulus, Barrett constant, Barrett shift
//   rN_valid/rN_ready       requester N operand handshake (ready is combinational)
//   rN_a, rN_b              requester N operands
//   dp_a, dp_b              registered operands to the datapath
//   dp_q, dp_mu, dp_k       configuration to the datapath
//   dp_t                    datapath result, LAT cycles after dp_a/dp_b
//   rspN_valid              one-cycle result strobe for requester N
//   rsp_t                   registered result, valid with rspN_valid
// -----------------------------------------------------------------------------
module modmul_scheduler #(
  parameter int LAT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [63:0] cfg_q,
  input  logic [30:0] cfg_mu,
  input  logic [7:0]  cfg_k,
  input  logic        r0_valid,
  input  logic        r1_valid,
  output logic        r0_ready,
  output logic        r1_ready,
  input  logic [63:0] r0_a,
  input  logic [63:0] r0_b,
  input  logic [63:0] r1_a,
  input  logic [63:0] r1_b,
  output logic [63:0] dp_a,
  output logic [63:0] dp_b,
  output logic [63:0] dp_q,
  output logic [30:0] dp_mu,
  output logic [7:0]  dp_k,
  input  logic [63:0] dp_t,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [63:0] rsp_t
);

  typedef enum logic [1:0] {UNCFG, RUN, DRAIN} state_t;

  // Issue-to-strobe spans LAT+2 cycles, so at full throughput up to LAT+2 ops
  // can be outstanding at once.
  localparam int CW = $clog2(LAT + 3);

  state_t          state, state_nxt;
  logic            prefer1;       // port 1 wins the next tie
  logic            grant0, grant1;
  logic            issue, cfg_hs, strobe;
  logic [LAT:0]    tag_v, tag_p;  // stage i describes dp_a/dp_b issued i+1 cycles ago
  logic [CW-1:0]   inflight;

  // Next state, config acceptance and grant selection.
  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    state_nxt = state;
    cfg_ready = 1'b0;
    grant0    = 1'b0;
    grant1    = 1'b0;
    unique case (state)
      UNCFG: begin
        cfg_ready = cfg_valid;
        if (cfg_valid) state_nxt = RUN;
      end
      RUN: begin
        if (cfg_valid) begin
          state_nxt = DRAIN;
        end else if (r0_valid && (!r1_valid || !prefer1)) begin
          grant0 = 1'b1;
        end else if (r1_valid) begin
          grant1 = 1'b1;
        end
      end
      DRAIN: begin
        cfg_ready = cfg_valid && (inflight == '0);
        // Either the new set is taken, or the request was withdrawn and the
        // old set stays in force.
        if (!cfg_valid || (inflight == '0)) state_nxt = RUN;
      end
      default: state_nxt = UNCFG;
    endcase
  end

  assign r0_ready = grant0;
  assign r1_ready = grant1;
  // A grant is only ever given to a valid requester, so a grant is an issue.
  assign issue    = grant0 | grant1;
  assign cfg_hs   = cfg_valid & cfg_ready;
  assign strobe   = rsp0_valid | rsp1_valid;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values and the order of statements does not matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= UNCFG;
      prefer1 <= 1'b0;
      dp_q    <= '0;
      dp_mu   <= '0;
      dp_k    <= '0;
      dp_a    <= '0;
      dp_b    <= '0;
    end else begin
      state <= state_nxt;
      if (cfg_hs) begin
        dp_q  <= cfg_q;
        dp_mu <= cfg_mu;
        dp_k  <= cfg_k;
      end
      if (issue) begin
        prefer1 <= grant0;
        dp_a    <= grant1 ? r1_a : r0_a;
        dp_b    <= grant1 ? r1_b : r0_b;
      end
    end
  end

  // Tag pipeline, result capture and in-flight count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the tag shift register is reset on purpose: an op that was in
      // flight when reset hit must never produce a strobe afterwards.
      tag_v      <= '0;
      tag_p      <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_t      <= '0;
      inflight   <= '0;
    end else begin
      tag_v      <= {tag_v[LAT-1:0], issue};
      tag_p      <= {tag_p[LAT-1:0], grant1};
      rsp0_valid <= tag_v[LAT] & ~tag_p[LAT];
      rsp1_valid <= tag_v[LAT] &  tag_p[LAT];
      if (tag_v[LAT]) rsp_t <= dp_t;
      unique case ({issue, strobe})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_modmul_scheduler.sv
// -----------------------------------------------------------------------------
// tb_modmul_scheduler
//
// Drives the scheduler with directed and random traffic. A behavioural
// datapath (LAT-cycle pipeline of (a*b) mod q) answers on dp_t. A negedge
// monitor keeps a reference model of the scheduler's rules: round-robin
// grants, config acceptance only when nothing is outstanding, and results
// due LAT+2 cycles after issue. It also holds a scoreboard of expected
// responses.
// -----------------------------------------------------------------------------
module tb_modmul_scheduler;
  localparam int LAT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid, cfg_ready;
  logic [63:0] cfg_q;
  logic [30:0] cfg_mu;
  logic [7:0]  cfg_k;
  logic        r0_valid, r1_valid, r0_ready, r1_ready;
  logic [63:0] r0_a, r0_b, r1_a, r1_b;
  logic [63:0] dp_a, dp_b, dp_q, dp_t;
  logic [30:0] dp_mu;
  logic [7:0]  dp_k;
  logic        rsp0_valid, rsp1_valid;
  logic [63:0] rsp_t;

  always #5 clk = ~clk;

  modmul_scheduler #(.LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_q(cfg_q), .cfg_mu(cfg_mu), .cfg_k(cfg_k),
    .r0_valid(r0_valid), .r1_valid(r1_valid),
    .r0_ready(r0_ready), .r1_ready(r1_ready),
    .r0_a(r0_a), .r0_b(r0_b), .r1_a(r1_a), .r1_b(r1_b),
    .dp_a(dp_a), .dp_b(dp_b), .dp_q(dp_q), .dp_mu(dp_mu), .dp_k(dp_k),
    .dp_t(dp_t),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_t(rsp_t)
  );

  function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b,
                                         input logic [63:0] q);
    logic [127:0] p;
    if (q == 64'd0) return 64'd0;
    p = ({64'd0, a} * {64'd0, b}) % {64'd0, q};
    return p[63:0];
  endfunction

  // Behavioural datapath: result appears on dp_t LAT cycles after dp_a/dp_b.
  logic [63:0] pipe [LAT];
  initial for (int i = 0; i < LAT; i++) pipe[i] = 64'd0;
  always @(posedge clk) begin
    pipe[0] <= mulmod(dp_a, dp_b, dp_q);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign dp_t = pipe[LAT-1];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    logic        port;
    logic [63:0] t;
    int          due;
  } exp_t;

  exp_t        sb[$];
  bit          m_cfgd, m_drain, m_pref1;
  logic [63:0] m_q, m_dpa, m_dpb, m_rsp;
  logic [30:0] m_mu;
  logic [7:0]  m_k;

  always @(negedge clk) begin
    bit   exp_cr, allow, g0, g1, exp_s, hs;
    exp_t e;
    cyc++;
    if (!rst_n) begin
      check("reset_outputs",
            {cfg_ready, r0_ready, r1_ready, rsp0_valid, rsp1_valid,
             |dp_a, |dp_b, |dp_q, |dp_mu, |dp_k, |rsp_t}, 0);
      sb.delete();
      m_cfgd = 0; m_drain = 0; m_pref1 = 0;
      m_q = 0; m_mu = 0; m_k = 0; m_dpa = 0; m_dpb = 0; m_rsp = 0;
    end else begin
      // A new set is taken at once when unconfigured, otherwise only once a
      // pending request has waited a cycle and nothing is outstanding.
      exp_cr = !m_cfgd ? cfg_valid : (m_drain && cfg_valid && sb.size() == 0);
      check("cfg_ready", cfg_ready, exp_cr);

      allow = m_cfgd && !m_drain && !cfg_valid;
      g0    = allow && r0_valid && (!r1_valid || !m_pref1);
      g1    = allow && r1_valid && !g0;
      check("grant", {r1_ready, r0_ready}, {g1, g0});

      check("dp_operands", {dp_a, dp_b}, {m_dpa, m_dpb});
      check("dp_config", {dp_q, dp_mu, dp_k}, {m_q, m_mu, m_k});

      exp_s = (sb.size() > 0) && (sb[0].due == cyc);
      check("rsp_strobe", {rsp1_valid, rsp0_valid},
            exp_s ? (sb[0].port ? 2'b10 : 2'b01) : 2'b00);
      if (exp_s) begin
        e = sb.pop_front();
        m_rsp = e.t;
      end
      check(exp_s ? "rsp_t" : "rsp_t_hold", rsp_t, m_rsp);

      if (g0 || g1) begin
        e.port = g1;
        e.t    = g1 ? mulmod(r1_a, r1_b, m_q) : mulmod(r0_a, r0_b, m_q);
        e.due  = cyc + LAT + 2;
        sb.push_back(e);
        m_dpa   = g1 ? r1_a : r0_a;
        m_dpb   = g1 ? r1_b : r0_b;
        m_pref1 = g0;
      end

      hs      = cfg_valid && exp_cr;
      m_drain = m_cfgd && cfg_valid && !hs;
      if (hs) begin
        m_cfgd = 1; m_q = cfg_q; m_mu = cfg_mu; m_k = cfg_k;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [63:0] q, input logic [30:0] mu, input logic [7:0] k);
    bit done = 0;
    cfg_valid = 1; cfg_q = q; cfg_mu = mu; cfg_k = k;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      done = cfg_ready;
    end
    tick();
    cfg_valid = 0;
    check("cfg_timeout", done, 1);
  endtask

  task automatic req(input bit port, input logic [63:0] a, input logic [63:0] b);
    bit done = 0;
    if (port) begin r1_valid = 1; r1_a = a; r1_b = b; end
    else      begin r0_valid = 1; r0_a = a; r0_b = b; end
    for (int i = 0; i < 32 && !done; i++) begin
      @(negedge clk);
      done = port ? (r1_valid && r1_ready) : (r0_valid && r0_ready);
    end
    tick();
    if (port) r1_valid = 0; else r0_valid = 0;
    check(port ? "req1_timeout" : "req0_timeout", done, 1);
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int i = 0; i < 200 && !idle; i++) begin
      @(posedge clk);
      idle = (sb.size() == 0);
    end
    #1;
    check("drain_timeout", idle, 1);
  endtask

  initial begin
    bit cfg_seen;
    rst_n = 1; cfg_valid = 0; cfg_q = 0; cfg_mu = 0; cfg_k = 0;
    r0_valid = 0; r1_valid = 0; r0_a = 0; r0_b = 0; r1_a = 0; r1_b = 0;
    #1 rst_n = 0;
    repeat (3) tick();
    rst_n = 1;

    // Requests before any configuration must not be granted.
    r0_valid = 1; r1_valid = 1; r0_a = 64'd11; r0_b = 64'd12; r1_a = 64'd13; r1_b = 64'd14;
    repeat (5) tick();
    r0_valid = 0; r1_valid = 0;

    load_cfg(64'd97, 31'd168, 8'd7);

    // Simultaneous requests: port 0 wins the first tie, port 1 follows.
    fork
      req(0, 64'd5, 64'd7);
      req(1, 64'd10, 64'd10);
    join
    req(0, 64'd50, 64'd60);
    wait_idle();

    // Both held valid for six cycles: grants alternate.
    r0_valid = 1; r1_valid = 1;
    for (int i = 0; i < 6; i++) begin
      r0_a = 64'($urandom_range(0, 1000)); r0_b = 64'($urandom_range(0, 1000));
      r1_a = 64'($urandom_range(0, 1000)); r1_b = 64'($urandom_range(0, 1000));
      tick();
    end
    r0_valid = 0; r1_valid = 0;
    wait_idle();

    // Reconfigure with three ops in flight, then use the new modulus.
    r0_valid = 1;
    for (int i = 0; i < 3; i++) begin
      r0_a = 64'(i + 20); r0_b = 64'(i + 30);
      tick();
    end
    r0_valid = 0;
    load_cfg(64'd101, 31'd162, 8'd7);
    req(0, 64'd50, 64'd60);
    wait_idle();

    // Random traffic with occasional (sometimes withdrawn) reconfiguration.
    cfg_seen = 0;
    for (int c = 0; c < 400; c++) begin
      r0_valid = 1'($urandom_range(0, 1));
      r1_valid = 1'($urandom_range(0, 1));
      r0_a = {$urandom, $urandom}; r0_b = {$urandom, $urandom};
      r1_a = {$urandom, $urandom}; r1_b = {$urandom, $urandom};
      if (cfg_valid && (cfg_seen || $urandom_range(0, 15) == 0)) begin
        cfg_valid = 0;
      end else if (!cfg_valid && $urandom_range(0, 39) == 0) begin
        cfg_valid = 1;
        cfg_q  = {$urandom, $urandom} | 64'd1;
        cfg_mu = 31'($urandom);
        cfg_k  = 8'($urandom);
      end
      @(negedge clk);
      cfg_seen = cfg_valid && cfg_ready;
      tick();
    end
    cfg_valid = 0; r0_valid = 0; r1_valid = 0;
    wait_idle();

    // Reset with four ops in flight: all of them are discarded.
    load_cfg(64'd97, 31'd168, 8'd7);
    r0_valid = 1; r1_valid = 1;
    repeat (4) tick();
    rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
    repeat (5) tick();
    r0_valid = 0; r1_valid = 0;
    repeat (LAT + 6) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
